// File: rtl/qrd_in_skew.sv
// Input skew buffer for the 4x4 complex QRD systolic array.
// Registers one column per accept, then delays lane k by k-1 extra cycles so the
// array sees the triangular wavefront. Each element carries first/last tags and
// the FSM inserts a fixed bubble gap between matrices.
module qrd_in_skew #(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned NCOL    = 4,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] col_in_1_r,
  input  logic [WIDTH-1:0] col_in_2_r,
  input  logic [WIDTH-1:0] col_in_3_r,
  input  logic [WIDTH-1:0] col_in_4_r,
  input  logic [WIDTH-1:0] col_in_1_i,
  input  logic [WIDTH-1:0] col_in_2_i,
  input  logic [WIDTH-1:0] col_in_3_i,
  input  logic [WIDTH-1:0] col_in_4_i,
  output logic [WIDTH-1:0] row_out_1_r,
  output logic [WIDTH-1:0] row_out_2_r,
  output logic [WIDTH-1:0] row_out_3_r,
  output logic [WIDTH-1:0] row_out_4_r,
  output logic [WIDTH-1:0] row_out_1_i,
  output logic [WIDTH-1:0] row_out_2_i,
  output logic [WIDTH-1:0] row_out_3_i,
  output logic [WIDTH-1:0] row_out_4_i,
  output logic [3:0]       out_valid,
  output logic [3:0]       out_first,
  output logic [3:0]       out_last,
  output logic             busy
);

  localparam int unsigned    CntW    = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [CntW-1:0] LastCol = CntW'(NCOL - 1);
  localparam logic [3:0]      GapInit = 4'(MIN_GAP);

  typedef enum logic [1:0] {StIdle, StLoad, StGap} state_e;

  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } elem_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] col_cnt_q, col_cnt_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic            accept;
  logic            last_col;

  logic [WIDTH-1:0] in_r [4];
  logic [WIDTH-1:0] in_i [4];
  elem_t            s0_d [4];
  elem_t            lane_out [4];
  logic [3:0]       lane_busy;

  assign in_r[0] = col_in_1_r;
  assign in_r[1] = col_in_2_r;
  assign in_r[2] = col_in_3_r;
  assign in_r[3] = col_in_4_r;
  assign in_i[0] = col_in_1_i;
  assign in_i[1] = col_in_2_i;
  assign in_i[2] = col_in_3_i;
  assign in_i[3] = col_in_4_i;

  assign in_ready = (state_q != StGap);
  assign accept   = in_valid & in_ready;
  assign last_col = (col_cnt_q == LastCol);

  // Column counter and inter-matrix gap sequencing.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          if (last_col) begin
            col_cnt_d = '0;
            if (MIN_GAP == 0) begin
              state_d = StIdle;
            end else begin
              state_d   = StGap;
              gap_cnt_d = GapInit;
            end
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
            state_d   = StLoad;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q <= 4'd1) begin
          state_d   = StIdle;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      col_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Stage-0 contents: tagged column on accept, all-zero slot otherwise.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      s0_d[k] = '0;
      if (accept) begin
        s0_d[k].valid = 1'b1;
        s0_d[k].first = (col_cnt_q == '0);
        s0_d[k].last  = last_col;
        s0_d[k].re    = in_r[k];
        s0_d[k].im    = in_i[k];
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    // Stage 0 plus k delay stages; shifts every cycle, no backpressure.
    elem_t      pipe_q [k+1];
    logic [k:0] vld;

    // Lane delay line.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= k; s++) begin
          pipe_q[s] <= '0;
        end
      end else begin
        pipe_q[0] <= s0_d[k];
        for (int s = 1; s <= k; s++) begin
          pipe_q[s] <= pipe_q[s-1];
        end
      end
    end

    for (genvar s = 0; s <= k; s++) begin : g_vld
      assign vld[s] = pipe_q[s].valid;
    end

    assign lane_busy[k] = |vld;
    assign lane_out[k]  = pipe_q[k];
    assign out_valid[k] = pipe_q[k].valid;
    assign out_first[k] = pipe_q[k].first;
    assign out_last[k]  = pipe_q[k].last;
  end

  assign row_out_1_r = lane_out[0].re;
  assign row_out_2_r = lane_out[1].re;
  assign row_out_3_r = lane_out[2].re;
  assign row_out_4_r = lane_out[3].re;
  assign row_out_1_i = lane_out[0].im;
  assign row_out_2_i = lane_out[1].im;
  assign row_out_3_i = lane_out[2].im;
  assign row_out_4_i = lane_out[3].im;

  assign busy = (state_q != StIdle) | (|lane_busy);

endmodule

// File: tb/tb_qrd_in_skew.sv
// Bench for qrd_in_skew: per-cycle vector table for the skew/tag/gap behaviour,
// plus directed sequences for extreme values, mid-matrix reset and MIN_GAP=0.
module tb_qrd_in_skew;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] cr [4];
  logic [W-1:0] ci [4];

  logic         rdy, busy;
  logic [3:0]   ov, of, ol;
  logic [W-1:0] orr [4];
  logic [W-1:0] ori [4];

  logic         z_rdy, z_busy;
  logic [3:0]   z_v, z_f, z_l;
  logic [W-1:0] zr [4];
  logic [W-1:0] zi [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qrd_in_skew #(.WIDTH(W), .NCOL(4), .MIN_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy),
    .col_in_1_r(cr[0]), .col_in_2_r(cr[1]), .col_in_3_r(cr[2]), .col_in_4_r(cr[3]),
    .col_in_1_i(ci[0]), .col_in_2_i(ci[1]), .col_in_3_i(ci[2]), .col_in_4_i(ci[3]),
    .row_out_1_r(orr[0]), .row_out_2_r(orr[1]), .row_out_3_r(orr[2]), .row_out_4_r(orr[3]),
    .row_out_1_i(ori[0]), .row_out_2_i(ori[1]), .row_out_3_i(ori[2]), .row_out_4_i(ori[3]),
    .out_valid(ov), .out_first(of), .out_last(ol), .busy(busy)
  );

  qrd_in_skew #(.WIDTH(W), .NCOL(4), .MIN_GAP(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_rdy),
    .col_in_1_r(cr[0]), .col_in_2_r(cr[1]), .col_in_3_r(cr[2]), .col_in_4_r(cr[3]),
    .col_in_1_i(ci[0]), .col_in_2_i(ci[1]), .col_in_3_i(ci[2]), .col_in_4_i(ci[3]),
    .row_out_1_r(zr[0]), .row_out_2_r(zr[1]), .row_out_3_r(zr[2]), .row_out_4_r(zr[3]),
    .row_out_1_i(zi[0]), .row_out_2_i(zi[1]), .row_out_3_i(zi[2]), .row_out_4_i(zi[3]),
    .out_valid(z_v), .out_first(z_f), .out_last(z_l), .busy(z_busy)
  );

  // One table row: stimulus before an edge, in_ready before it, outputs after it.
  // tags holds the column tag seen in each lane, nibble k-1 for lane k.
  typedef struct packed {
    logic        iv;
    logic [3:0]  tag;
    logic        rdy;
    logic        busy;
    logic [3:0]  v;
    logic [3:0]  f;
    logic [3:0]  l;
    logic [15:0] tags;
  } vec_t;

  vec_t         vecs [32];
  logic [W-1:0] xr [4];
  logic [W-1:0] xi [4];

  function automatic vec_t mk(logic iv, logic [3:0] tag, logic r, logic b,
                              logic [3:0] v, logic [3:0] f, logic [3:0] l,
                              logic [15:0] tags);
    vec_t t;
    t = '{iv: iv, tag: tag, rdy: r, busy: b, v: v, f: f, l: l, tags: tags};
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Element (r,c) of a tagged column: re = 16*r+tag, im = -(16*r+tag).
  task automatic drive(logic iv, logic [3:0] tag);
    in_valid = iv;
    for (int r = 0; r < 4; r++) begin
      cr[r] = W'(16 * (r + 1) + int'(tag));
      ci[r] = W'(0 - (16 * (r + 1) + int'(tag)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Plain 4-column matrix, then drain through the gap.
    vecs[0]  = mk(1, 0,  1, 1, 4'b0001, 4'b0001, 4'b0000, 16'h0000);
    vecs[1]  = mk(1, 1,  1, 1, 4'b0011, 4'b0010, 4'b0000, 16'h0001);
    vecs[2]  = mk(1, 2,  1, 1, 4'b0111, 4'b0100, 4'b0000, 16'h0012);
    vecs[3]  = mk(1, 3,  1, 1, 4'b1111, 4'b1000, 4'b0001, 16'h0123);
    vecs[4]  = mk(0, 15, 0, 1, 4'b1110, 4'b0000, 4'b0010, 16'h1230);
    vecs[5]  = mk(0, 15, 0, 1, 4'b1100, 4'b0000, 4'b0100, 16'h2300);
    vecs[6]  = mk(0, 15, 1, 1, 4'b1000, 4'b0000, 4'b1000, 16'h3000);
    vecs[7]  = mk(0, 15, 1, 0, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
    // in_valid held across the boundary: offers 4 and 5 are refused.
    vecs[8]  = mk(1, 0,  1, 1, 4'b0001, 4'b0001, 4'b0000, 16'h0000);
    vecs[9]  = mk(1, 1,  1, 1, 4'b0011, 4'b0010, 4'b0000, 16'h0001);
    vecs[10] = mk(1, 2,  1, 1, 4'b0111, 4'b0100, 4'b0000, 16'h0012);
    vecs[11] = mk(1, 3,  1, 1, 4'b1111, 4'b1000, 4'b0001, 16'h0123);
    vecs[12] = mk(1, 4,  0, 1, 4'b1110, 4'b0000, 4'b0010, 16'h1230);
    vecs[13] = mk(1, 5,  0, 1, 4'b1100, 4'b0000, 4'b0100, 16'h2300);
    vecs[14] = mk(1, 6,  1, 1, 4'b1001, 4'b0001, 4'b1000, 16'h3006);
    vecs[15] = mk(1, 7,  1, 1, 4'b0011, 4'b0010, 4'b0000, 16'h0067);
    vecs[16] = mk(1, 8,  1, 1, 4'b0111, 4'b0100, 4'b0000, 16'h0678);
    vecs[17] = mk(1, 9,  1, 1, 4'b1111, 4'b1000, 4'b0001, 16'h6789);
    vecs[18] = mk(0, 15, 0, 1, 4'b1110, 4'b0000, 4'b0010, 16'h7890);
    vecs[19] = mk(0, 15, 0, 1, 4'b1100, 4'b0000, 4'b0100, 16'h8900);
    vecs[20] = mk(0, 15, 1, 1, 4'b1000, 4'b0000, 4'b1000, 16'h9000);
    vecs[21] = mk(0, 15, 1, 0, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
    // Bubble mid-matrix: in_valid 1,1,0,0,1,1.
    vecs[22] = mk(1, 0,  1, 1, 4'b0001, 4'b0001, 4'b0000, 16'h0000);
    vecs[23] = mk(1, 1,  1, 1, 4'b0011, 4'b0010, 4'b0000, 16'h0001);
    vecs[24] = mk(0, 15, 1, 1, 4'b0110, 4'b0100, 4'b0000, 16'h0010);
    vecs[25] = mk(0, 15, 1, 1, 4'b1100, 4'b1000, 4'b0000, 16'h0100);
    vecs[26] = mk(1, 2,  1, 1, 4'b1001, 4'b0000, 4'b0000, 16'h1002);
    vecs[27] = mk(1, 3,  1, 1, 4'b0011, 4'b0000, 4'b0001, 16'h0023);
    vecs[28] = mk(0, 15, 0, 1, 4'b0110, 4'b0000, 4'b0010, 16'h0230);
    vecs[29] = mk(0, 15, 0, 1, 4'b1100, 4'b0000, 4'b0100, 16'h2300);
    vecs[30] = mk(0, 15, 1, 1, 4'b1000, 4'b0000, 4'b1000, 16'h3000);
    vecs[31] = mk(0, 15, 1, 0, 4'b0000, 4'b0000, 4'b0000, 16'h0000);

    xr[0] = 14'h1FFF; xr[1] = 14'h2000; xr[2] = 14'h0000; xr[3] = 14'h3FFF;
    xi[0] = 14'h2000; xi[1] = 14'h1FFF; xi[2] = 14'h3FFF; xi[3] = 14'h0001;

    // Reset state.
    rst_n = 1'b0;
    drive(1'b0, 4'd15);
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(rdy), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset out_valid", 32'(ov), 32'd0);
    chk("reset row_out_4_r", 32'(orr[3]), 32'd0);
    #2 rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 32; i++) begin
      drive(vecs[i].iv, vecs[i].tag);
      chk($sformatf("row%0d in_ready", i), 32'(rdy), 32'(vecs[i].rdy));
      step();
      chk($sformatf("row%0d out_valid", i), 32'(ov), 32'(vecs[i].v));
      chk($sformatf("row%0d out_first", i), 32'(of), 32'(vecs[i].f));
      chk($sformatf("row%0d out_last", i), 32'(ol), 32'(vecs[i].l));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      for (int k = 0; k < 4; k++) begin
        logic [W-1:0] er, ei;
        int           val;
        val = 16 * (k + 1) + int'(vecs[i].tags[4*k +: 4]);
        er  = vecs[i].v[k] ? W'(val) : '0;
        ei  = vecs[i].v[k] ? W'(0 - val) : '0;
        chk($sformatf("row%0d lane%0d re", i, k + 1), 32'(orr[k]), 32'(er));
        chk($sformatf("row%0d lane%0d im", i, k + 1), 32'(ori[k]), 32'(ei));
      end
    end

    // Extreme 14-bit values pass bit-exact through every lane.
    for (int j = 0; j < 7; j++) begin
      in_valid = (j < 4);
      for (int r = 0; r < 4; r++) begin
        cr[r] = (j < 4) ? xr[j] : xr[0];
        ci[r] = (j < 4) ? xi[j] : xi[0];
      end
      step();
      for (int k = 0; k < 4; k++) begin
        int c;
        c = j - k;
        chk($sformatf("extreme t%0d lane%0d re", j, k + 1), 32'(orr[k]),
            (c >= 0 && c <= 3) ? 32'(xr[c]) : 32'd0);
        chk($sformatf("extreme t%0d lane%0d im", j, k + 1), 32'(ori[k]),
            (c >= 0 && c <= 3) ? 32'(xi[c]) : 32'd0);
      end
    end
    drive(1'b0, 4'd15);
    step();

    // Asynchronous reset after the second column of a matrix.
    drive(1'b1, 4'd0);
    step();
    drive(1'b1, 4'd1);
    step();
    chk("prereset out_valid", 32'(ov), 32'b0011);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(ov), 32'd0);
    chk("async reset out_first", 32'(of), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset in_ready", 32'(rdy), 32'd1);
    chk("async reset row_out_1_r", 32'(orr[0]), 32'd0);
    chk("async reset row_out_2_i", 32'(ori[1]), 32'd0);
    #1 rst_n = 1'b1;
    drive(1'b1, 4'd5);
    step();
    chk("post reset out_valid", 32'(ov), 32'b0001);
    chk("post reset out_first", 32'(of), 32'b0001);
    chk("post reset row_out_1_r", 32'(orr[0]), 32'd21);

    // MIN_GAP=0: two back-to-back matrices with no bubble.
    drive(1'b0, 4'd15);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 4'(j));
      chk($sformatf("gap0 c%0d in_ready", j), 32'(z_rdy), 32'd1);
      step();
      chk($sformatf("gap0 c%0d lane1 valid", j), 32'(z_v[0]), 32'd1);
      chk($sformatf("gap0 c%0d lane1 first", j), 32'(z_f[0]), 32'((j % 4) == 0));
      chk($sformatf("gap0 c%0d lane1 last", j), 32'(z_l[0]), 32'((j % 4) == 3));
      chk($sformatf("gap0 c%0d lane1 re", j), 32'(zr[0]), 32'(16 + j));
    end
    drive(1'b0, 4'd15);
    step();
    chk("gap0 lane1 drained", 32'(z_v[0]), 32'd0);
    chk("gap0 in_ready after", 32'(z_rdy), 32'd1);
    repeat (4) step();
    chk("gap0 busy drained", 32'(z_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
